// File: rtl/vga_axil_master_fsm.sv
// rtl/vga_axil_master_fsm.sv - AXI4-Lite initiator turning single native read/write commands into AXI-Lite transactions

package vga_axil_pkg;
    localparam int AXIL_ADDR_W   = 32;
    localparam int AXIL_DATA_W   = 32;
    localparam int NATIVE_ADDR_W = 30;

    typedef logic [AXIL_ADDR_W-1:0]   axil_addr_t;
    typedef logic [AXIL_DATA_W-1:0]   axil_data_t;
    typedef logic [NATIVE_ADDR_W-1:0] native_addr_t;
    typedef logic [1:0]               axil_resp_t;

    localparam axil_resp_t AXIL_RESP_OKAY = 2'b00;

    // Native addresses count 32-bit words; AXI-Lite addresses count bytes.
    function automatic axil_addr_t native2axil_addr(input native_addr_t a);
        return axil_addr_t'({a, 2'b00});
    endfunction

    function automatic native_addr_t axil2native_addr(input axil_addr_t a);
        return a[AXIL_ADDR_W-1:2];
    endfunction
endpackage

module vga_axil_master_fsm
    import vga_axil_pkg::*;
(
    input  logic         clk,
    input  logic         arst_n,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic         cmd_we_i,
    input  native_addr_t cmd_addr_i,
    input  axil_data_t   cmd_wdata_i,
    output logic         rsp_valid_o,
    output axil_data_t   rsp_rdata_o,
    output logic         rsp_err_o,
    output axil_addr_t   awaddr,
    output logic         awvalid,
    input  logic         awready,
    output logic [2:0]   awprot,
    output axil_data_t   wdata,
    output logic [3:0]   wstrb,
    output logic         wvalid,
    input  logic         wready,
    input  axil_resp_t   bresp,
    input  logic         bvalid,
    output logic         bready,
    output axil_addr_t   araddr,
    output logic [2:0]   arprot,
    output logic         arvalid,
    input  logic         arready,
    input  axil_data_t   rdata,
    input  axil_resp_t   rresp,
    input  logic         rvalid,
    output logic         rready
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA
    } state_t;

    state_t state_q;
    state_t state_d;

    logic cmd_fire;
    logic wr_both_done;

    // cmd_ready_o is only ever high in ST_IDLE, so this is the acceptance strobe.
    assign cmd_fire = cmd_valid_i & cmd_ready_o;

    // A write channel is finished when its valid already dropped or it handshakes now.
    assign wr_both_done = (~awvalid | awready) & (~wvalid | wready);

    assign awprot = 3'b000;
    assign arprot = 3'b000;

    // State register.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode from handshakes on the active channel.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    state_d = cmd_we_i ? ST_WR_ADDR_DATA : ST_RD_ADDR;
                end
            end
            ST_WR_ADDR_DATA: begin
                if (wr_both_done) begin
                    state_d = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (bvalid && bready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_ADDR: begin
                if (arvalid && arready) begin
                    state_d = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (rvalid && rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered AXI and native outputs, updated on the same edges as the state.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            awaddr      <= '0;
            awvalid     <= 1'b0;
            wdata       <= '0;
            wstrb       <= '0;
            wvalid      <= 1'b0;
            bready      <= 1'b0;
            araddr      <= '0;
            arvalid     <= 1'b0;
            rready      <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            wstrb       <= 4'hF;
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_o <= ~cmd_fire;
                    if (cmd_fire) begin
                        if (cmd_we_i) begin
                            awaddr  <= native2axil_addr(cmd_addr_i);
                            wdata   <= cmd_wdata_i;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end else begin
                            araddr  <= native2axil_addr(cmd_addr_i);
                            arvalid <= 1'b1;
                        end
                    end
                end
                ST_WR_ADDR_DATA: begin
                    awvalid <= awvalid & ~awready;
                    wvalid  <= wvalid & ~wready;
                    if (wr_both_done) begin
                        bready <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid && bready) begin
                        bready      <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= (bresp != AXIL_RESP_OKAY);
                        cmd_ready_o <= 1'b1;
                    end
                end
                ST_RD_ADDR: begin
                    if (arvalid && arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid && rready) begin
                        rready      <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_rdata_o <= rdata;
                        rsp_err_o   <= (rresp != AXIL_RESP_OKAY);
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vga_axil_master_fsm.sv
// tb/tb_vga_axil_master_fsm.sv - self-checking bench for vga_axil_master_fsm with a latency-programmable AXI-Lite slave

module tb_vga_axil_master_fsm;
    import vga_axil_pkg::*;

    logic         clk;
    logic         arst_n;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic         cmd_we_i;
    native_addr_t cmd_addr_i;
    axil_data_t   cmd_wdata_i;
    logic         rsp_valid_o;
    axil_data_t   rsp_rdata_o;
    logic         rsp_err_o;
    axil_addr_t   awaddr;
    logic         awvalid;
    logic         awready;
    logic [2:0]   awprot;
    axil_data_t   wdata;
    logic [3:0]   wstrb;
    logic         wvalid;
    logic         wready;
    axil_resp_t   bresp;
    logic         bvalid;
    logic         bready;
    axil_addr_t   araddr;
    logic [2:0]   arprot;
    logic         arvalid;
    logic         arready;
    axil_data_t   rdata;
    axil_resp_t   rresp;
    logic         rvalid;
    logic         rready;

    vga_axil_master_fsm dut (
        .clk(clk), .arst_n(arst_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
        .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awprot(awprot),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } slv_rsp_t;

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } txn_t;

    slv_rsp_t slv_q[$];
    txn_t     exp_q[$];

    int checks = 0;
    int errors = 0;

    int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;
    logic [31:0] model_rdata = '0;
    int cyc = 0;
    int rsp_pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rsp_valid_o) rsp_pulses <= rsp_pulses + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_wide(input string tag, input logic [145:0] obs, input logic [145:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [145:0] all_outs();
        return {cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, awaddr, awvalid, awprot,
                wdata, wstrb, wvalid, bready, araddr, arprot, arvalid, rready};
    endfunction

    // Slave: each channel's ready rises after a programmed number of waiting cycles,
    // responses follow the captured request after a programmed delay.
    initial begin : slave
        int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, idx;
        bit aw_got, w_got, ar_got, b_fire, r_fire;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0; idx = 0;
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            if (!arst_n) begin
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                idx = slv_q.size();
                continue;
            end
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            if (!bvalid && aw_got && w_got) begin
                if (b_cnt >= b_lat) begin
                    bvalid = 1;
                    bresp = (idx < slv_q.size()) ? slv_q[idx].resp : 2'b00;
                    idx++;
                    aw_got = 0; w_got = 0; b_cnt = 0;
                end else b_cnt++;
            end
            if (bvalid && bready) b_fire = 1;
            awready = 0;
            if (awvalid && !aw_got) begin
                if (aw_cnt >= aw_lat) begin
                    awready = 1; aw_got = 1; aw_cnt = 0; s_awaddr = awaddr;
                end else aw_cnt++;
            end
            wready = 0;
            if (wvalid && !w_got) begin
                if (w_cnt >= w_lat) begin
                    wready = 1; w_got = 1; w_cnt = 0; s_wdata = wdata; s_wstrb = wstrb;
                end else w_cnt++;
            end
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (!rvalid && ar_got) begin
                if (r_cnt >= r_lat) begin
                    rvalid = 1;
                    rresp = (idx < slv_q.size()) ? slv_q[idx].resp : 2'b00;
                    rdata = (idx < slv_q.size()) ? slv_q[idx].data : 32'h0;
                    idx++;
                    ar_got = 0; r_cnt = 0;
                end else r_cnt++;
            end
            if (rvalid && rready) r_fire = 1;
            arready = 0;
            if (arvalid && !ar_got) begin
                if (ar_cnt >= ar_lat) begin
                    arready = 1; ar_got = 1; ar_cnt = 0; s_araddr = araddr;
                end else ar_cnt++;
            end
        end
    end

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!cmd_ready_o && k < 100) begin @(negedge clk); k++; end
        check1(tag, cmd_ready_o, 1'b1);
    endtask

    task automatic present(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                           input logic [1:0] resp, input logic [31:0] rd);
        txn_t t;
        slv_rsp_t s;
        cmd_valid_i = 1; cmd_we_i = we; cmd_addr_i = addr; cmd_wdata_i = wd;
        t.we = we; t.addr = addr; t.wdata = wd; t.resp = resp; t.rdata = rd;
        exp_q.push_back(t);
        s.resp = resp; s.data = rd;
        slv_q.push_back(s);
    endtask

    task automatic start_cmd(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                             input logic [1:0] resp, input logic [31:0] rd);
        wait_ready("start_ready");
        present(we, addr, wd, resp, rd);
        @(negedge clk);
        cmd_valid_i = 0;
    endtask

    task automatic check_rsp();
        txn_t t;
        t = exp_q.pop_front();
        check1("rsp_valid", rsp_valid_o, 1'b1);
        check1("rsp_with_ready", cmd_ready_o, 1'b1);
        check1("rsp_err", rsp_err_o, t.resp != 2'b00);
        if (t.we) begin
            check32("awaddr", s_awaddr, 32'(t.addr) * 4);
            check32("wdata", s_wdata, t.wdata);
            check32("wstrb", 32'(s_wstrb), 32'hF);
        end else begin
            model_rdata = t.rdata;
            check32("araddr", s_araddr, 32'(t.addr) * 4);
        end
        check32("rsp_rdata", rsp_rdata_o, model_rdata);
    endtask

    task automatic finish_cmd(input int lat0, output int lat);
        lat = lat0;
        while (!rsp_valid_o && lat < 200) begin @(negedge clk); lat++; end
        check_rsp();
        @(negedge clk);
        check1("rsp_one_cycle", rsp_valid_o, 1'b0);
    endtask

    task automatic do_cmd(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                          input logic [1:0] resp, input logic [31:0] rd, output int lat);
        start_cmd(we, addr, wd, resp, rd);
        finish_cmd(1, lat);
    endtask

    initial begin : main
        int lat;
        int prev_cyc;
        int p0;
        arst_n = 0; cmd_valid_i = 0; cmd_we_i = 0; cmd_addr_i = '0; cmd_wdata_i = '0;
        repeat (2) @(negedge clk);
        check_wide("reset_outputs", all_outs(), '0);
        arst_n = 1;
        check1("ready_before_edge", cmd_ready_o, 1'b0);
        @(negedge clk);
        check1("ready_after_release", cmd_ready_o, 1'b1);

        // Single write to an always-ready slave.
        start_cmd(1'b1, 30'h10, 32'hDEADBEEF, 2'b00, 32'h0);
        check32("w1_awaddr", awaddr, 32'h40);
        check32("w1_wdata", wdata, 32'hDEADBEEF);
        check32("w1_wstrb", 32'(wstrb), 32'hF);
        check1("w1_awvalid", awvalid, 1'b1);
        check1("w1_wvalid", wvalid, 1'b1);
        check1("w1_ready_low", cmd_ready_o, 1'b0);
        @(negedge clk);
        check1("w1_bready", bready, 1'b1);
        check1("w1_awvalid_drop", awvalid, 1'b0);
        finish_cmd(2, lat);
        check32("w1_latency", lat, 32'd3);

        // Write data channel held off for three cycles.
        w_lat = 3;
        start_cmd(1'b1, 30'($urandom), $urandom, 2'b00, 32'h0);
        check1("st_awvalid_t1", awvalid, 1'b1);
        @(negedge clk);
        check1("st_awvalid_t2", awvalid, 1'b0);
        check1("st_wvalid_t2", wvalid, 1'b1);
        repeat (2) @(negedge clk);
        check1("st_wvalid_t4", wvalid, 1'b1);
        check1("st_bready_t4", bready, 1'b0);
        @(negedge clk);
        check1("st_wvalid_t5", wvalid, 1'b0);
        check1("st_bready_t5", bready, 1'b1);
        finish_cmd(5, lat);
        check32("st_latency", lat, 32'd6);
        w_lat = 0;

        // Read with a four-cycle arready delay.
        ar_lat = 4;
        start_cmd(1'b0, 30'h3, 32'h0, 2'b00, 32'h12345678);
        for (int i = 0; i < 4; i++) begin
            check32("rd_araddr_stable", araddr, 32'hC);
            check1("rd_arvalid_held", arvalid, 1'b1);
            @(negedge clk);
        end
        finish_cmd(5, lat);
        check32("rd_latency", lat, 32'd7);
        ar_lat = 0;

        do_cmd(1'b0, 30'h3FF, 32'h0, 2'b00, 32'hA5A50F0F, lat);
        check32("rd_min_latency", lat, 32'd3);

        // Error responses.
        do_cmd(1'b1, 30'h20, 32'h1, 2'b10, 32'h0, lat);
        do_cmd(1'b0, 30'h21, 32'h0, 2'b11, 32'hCAFEF00D, lat);

        // Back-to-back commands with cmd_valid_i held high.
        p0 = rsp_pulses;
        wait_ready("b2b_first_ready");
        prev_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                wait_ready("b2b_ready");
                check1("b2b_rsp_with_accept", rsp_valid_o, 1'b1);
                check32("b2b_gap", cyc - prev_cyc, 32'd3);
                check_rsp();
            end
            prev_cyc = cyc;
            present((i % 2) == 1, 30'($urandom), $urandom, 2'($urandom), $urandom);
            @(negedge clk);
        end
        cmd_valid_i = 0;
        finish_cmd(1, lat);
        @(negedge clk);
        check32("b2b_pulse_count", rsp_pulses - p0, 32'd8);

        // Randomized latencies, responses and data.
        for (int i = 0; i < 24; i++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            r_lat = $urandom_range(0, 3);
            do_cmd(1'($urandom), 30'($urandom), $urandom, 2'($urandom), $urandom, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0;

        // Reset while the write address is still pending.
        aw_lat = 50;
        start_cmd(1'b1, 30'h55, 32'h77, 2'b00, 32'h0);
        check1("rst_awvalid_before", awvalid, 1'b1);
        #2 arst_n = 0;
        #1 check_wide("rst_mid_outputs", all_outs(), '0);
        repeat (2) @(negedge clk);
        aw_lat = 0;
        exp_q.delete();
        model_rdata = 0;
        arst_n = 1;
        check1("rst_ready_before_edge", cmd_ready_o, 1'b0);
        @(negedge clk);
        check1("rst_ready_after_edge", cmd_ready_o, 1'b1);
        do_cmd(1'b0, 30'h7, 32'h0, 2'b00, 32'h0BADF00D, lat);
        check32("rst_read_latency", lat, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_axil_master_fsm.md
Name: vga_axil_master_fsm

Overview:
- AXI4-Lite initiator for the VGA subsystem: converts single native read/write commands into AXI-Lite transactions and returns a one-cycle response pulse.
- Used by the bench and the on-chip control sequencer to drive vga_axil_if slaves, including the VGA register/framebuffer slave.
- One outstanding transaction at a time; all AXI outputs are registered.

Parameters:
- None. Widths come from vga_axil_pkg: axil_addr_t (AXIL_ADDR_W=32), axil_data_t (AXIL_DATA_W=32), native_addr_t (NATIVE_ADDR_W), axil_resp_t (2).

Ports:
- clk  in  1  clock; one clock domain.
- arst_n  in  1  asynchronous active-low reset.
- cmd_valid_i  in  1  native command valid.
- cmd_ready_o  out  1  block idle, accepts a command.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_addr_i  in  NATIVE_ADDR_W  word address.
- cmd_wdata_i  in  32  write data.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  read data; held until next read completes.
- rsp_err_o  out  1  resp != OKAY; valid with rsp_valid_o.
- awaddr/awvalid/awready/awprot  out/out/in/out  32/1/1/3  AXI-Lite write-address channel.
- wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  AXI-Lite write-data channel.
- bresp/bvalid/bready  in/in/out  2/1/1  AXI-Lite write-response channel.
- araddr/arprot/arvalid/arready  out/out/out/in  32/3/1/1  AXI-Lite read-address channel.
- rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  AXI-Lite read-data channel.

Behaviour:
- Reset (arst_n low, asynchronous): every output is 0, including cmd_ready_o. FSM state is StIdle.
- cmd_ready_o rises on the first clk edge after reset release.
- States: StIdle, StWrAddrData, StWrResp, StRdAddr, StRdData.
- StIdle:
  - cmd_ready_o=1.
  - A command handshake (cmd_valid_i & cmd_ready_o) at edge T latches addr, data and we.
  - Next state is StWrAddrData (we=1) or StRdAddr (we=0).
  - cmd_ready_o=0 from T+1.
- Address conversion: awaddr/araddr = vga_axil_pkg::native2axil_addr(cmd_addr_i), i.e. native word address << 2, zero-extended. This is the inverse of axil2native_addr.
- Fixed signals: wstrb=4'hF, awprot=arprot=3'b000.
- StWrAddrData:
  - awvalid and wvalid both assert at T+1.
  - Each deasserts independently the cycle after its own handshake.
  - Once both handshakes are done (same cycle or different cycles), go to StWrResp.
- StWrResp:
  - bready=1.
  - On bvalid&bready: capture bresp; rsp_err_o=(bresp!=OKAY); rsp_valid_o=1 next cycle; bready=0; go to StIdle.
- StRdAddr: arvalid=1 until arready. Then go to StRdData.
- StRdData:
  - rready=1.
  - On rvalid&rready: rsp_rdata_o<=rdata; rsp_err_o=(rresp!=OKAY); rsp_valid_o=1 next cycle; rready=0; go to StIdle.
- rsp_valid_o:
  - Exactly one cycle wide, coincident with cmd_ready_o returning to 1.
  - A new command may be accepted in that same cycle.
  - No backpressure on the response.
- Minimum latency with an always-ready slave: command handshake T -> rsp_valid_o at T+3 (write and read).
- AXI stability: once asserted, awvalid/wvalid/arvalid and their addr/data stay constant until their handshake. There is no abort and no timeout.
- cmd_* inputs are ignored while cmd_ready_o=0.
- Responses arriving early are accepted only in their state: bvalid while still in StWrAddrData waits until bready asserts.
- rsp_rdata_o is not modified by writes.
- Reset mid-transaction: immediate return to StIdle with all outputs 0. The slave is reset together with this block.

Test Plan:
- Write, always-ready slave: cmd addr=0x10, wdata=0xDEADBEEF, we=1 -> awaddr=0x40, wdata=0xDEADBEEF, wstrb=F at T+1; bready at T+2; rsp_valid_o=1, rsp_err_o=0 at T+3.
- Staggered write handshakes: awready at T+1, wready held low until T+4 -> awvalid drops at T+2, wvalid held through T+4, bready from T+5, exactly one rsp_valid_o pulse.
- Read: cmd addr=0x3, slave returns rdata=0x12345678, rresp=OKAY after 4-cycle arready delay -> araddr=0xC stable while waiting, rsp_rdata_o=0x12345678, rsp_err_o=0.
- Error response: bresp=SLVERR (2'b10) -> rsp_err_o=1 with rsp_valid_o. Then read with rresp=DECERR -> rsp_err_o=1, rsp_rdata_o updated.
- Back-to-back commands: cmd_valid_i held high with alternating we -> next command accepted in the rsp_valid_o cycle; no idle gap; no command lost or duplicated.
- Reset mid-write: arst_n low while awvalid=1 -> all outputs 0 immediately; cmd_ready_o=1 one clk edge after release.
